// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one result bit per clock, with a start/busy/done handshake and HI/LO outputs.
module mdu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero,
   output logic             overflow
);

   localparam int             CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);
   localparam logic [1:0]     OP_DIV     = 2'd2;
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_b_reg;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               div_by_zero;
   logic               min_by_neg1;

   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic               b_zero;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_step;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next = (op[1] && b_zero) ? FIX : CALC;
               end
            end
            CALC: begin
               if (count == LAST_COUNT) begin
                  state_next = FIX;
               end
            end
            FIX: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & op_a[WIDTH-1];
      b_neg     = signed_op & op_b[WIDTH-1];
      b_zero    = (op_b == '0);
      mag_a_in  = a_neg ? (~op_a + 1'b1) : op_a;
      mag_b_in  = b_neg ? (~op_b + 1'b1) : op_b;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, remaining dividend bits / quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b_reg} : '0);
      mul_step  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, mag_b_reg};
      div_step  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = neg_lo ? (~acc + 1'b1) : acc;
      quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         fix_hi = rem_fix;
         fix_lo = quo_fix;
      end
   end

   // Divide-by-zero preloads acc with {op_a, all ones} and clears the sign
   // flags, so FIX writes that pattern through the ordinary divide path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         acc         <= '0;
         mag_b_reg   <= '0;
         is_div      <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         div_by_zero <= 1'b0;
         min_by_neg1 <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_zero    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     busy        <= 1'b1;
                     count       <= '0;
                     is_div      <= op[1];
                     mag_b_reg   <= mag_b_in;
                     div_by_zero <= op[1] && b_zero;
                     min_by_neg1 <= (op == OP_DIV) && (op_a == MIN_VAL) && (op_b == '1);
                     if (op[1] && b_zero) begin
                        acc    <= {op_a, {WIDTH{1'b1}}};
                        neg_lo <= 1'b0;
                        neg_hi <= 1'b0;
                     end else begin
                        acc    <= {{WIDTH{1'b0}}, mag_a_in};
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                     end
                  end
               end
               CALC: begin
                  count <= count + COUNT_ONE;
                  acc   <= is_div ? div_step : mul_step;
               end
               FIX: begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  hi       <= fix_hi;
                  lo       <= fix_lo;
                  div_zero <= div_by_zero;
                  overflow <= min_by_neg1;
               end
               default: begin
                  busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32): directed cases, randomized ops
// against an arithmetic reference model, flush, busy-ignore, back-to-back and async reset.
module tb_mdu_iterative;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         flush = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_zero;
   logic         overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;
   logic         last_z = 1'b0;
   logic         last_v = 1'b0;

   typedef struct {
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] h;
      logic [W-1:0] l;
      logic         z;
      logic         v;
      int           lat;
   } vec_t;

   mdu_iterative #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .op_a     (op_a),
      .op_b     (op_b),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] mh, output logic [W-1:0] ml,
                                 output logic mz, output logic mv);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      mz = 1'b0;
      mv = 1'b0;
      mh = '0;
      ml = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: begin
            p  = 64'(sa * sb);
            mh = p[63:32];
            ml = p[31:0];
         end
         2'd1: begin
            p  = {32'b0, a} * {32'b0, b};
            mh = p[63:32];
            ml = p[31:0];
         end
         default: begin
            if (b == '0) begin
               mz = 1'b1;
               mh = a;
               ml = '1;
            end else if (o == 2'd2) begin
               q  = sa / sb;
               r  = sa % sb;
               ml = 32'(q);
               mh = 32'(r);
               mv = (q > 64'sd2147483647);
            end else begin
               ml = a / b;
               mh = a % b;
            end
         end
      endcase
   endfunction

   task automatic wait_done(inout int edges);
      while (done !== 1'b1 && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Edge numbering: the accepting edge is edge 1.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      wait_done(edges);
   endtask

   task automatic test_reset();
      #12;
      vectors++; if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      vectors++; if (hi !== '0)         begin miscompares++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
      vectors++; if (lo !== '0)         begin miscompares++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
      vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_div_zero: got %b expected 0", div_zero); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      vec_t tbl[6];
      int   edges;
      tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 34};
      tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 34};
      tbl[2] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 34};
      tbl[3] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 34};
      tbl[4] = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b0, 2};
      tbl[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b1, 34};
      for (int i = 0; i < 6; i++) begin
         issue(tbl[i].o, tbl[i].a, tbl[i].b, edges);
         vectors++; if (edges !== tbl[i].lat)  begin miscompares++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, edges, tbl[i].lat); end
         vectors++; if (hi !== tbl[i].h)       begin miscompares++; $display("[TB] FAIL dir%0d_hi: got %h expected %h", i, hi, tbl[i].h); end
         vectors++; if (lo !== tbl[i].l)       begin miscompares++; $display("[TB] FAIL dir%0d_lo: got %h expected %h", i, lo, tbl[i].l); end
         vectors++; if (div_zero !== tbl[i].z) begin miscompares++; $display("[TB] FAIL dir%0d_div_zero: got %b expected %b", i, div_zero, tbl[i].z); end
         vectors++; if (overflow !== tbl[i].v) begin miscompares++; $display("[TB] FAIL dir%0d_overflow: got %b expected %b", i, overflow, tbl[i].v); end
         last_hi = tbl[i].h;
         last_lo = tbl[i].l;
         last_z  = tbl[i].z;
         last_v  = tbl[i].v;
      end
   endtask

   task automatic test_random();
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eh;
      logic [W-1:0] el;
      logic         ez;
      logic         ev;
      int           lat;
      int           edges;
      int           sel;
      for (int i = 0; i < 60; i++) begin
         o   = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = '0;
         else if (sel == 1) b = 32'($urandom_range(1, 15));
         else if (sel == 2) b = -32'($urandom_range(1, 15));
         else if (sel == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (sel == 4) a = 32'($urandom_range(0, 1000));
         model(o, a, b, eh, el, ez, ev);
         lat = (o[1] && b == '0) ? 2 : 34;
         issue(o, a, b, edges);
         vectors++; if (edges !== lat)   begin miscompares++; $display("[TB] FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d expected %0d", i, o, a, b, edges, lat); end
         vectors++; if (hi !== eh)       begin miscompares++; $display("[TB] FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, eh); end
         vectors++; if (lo !== el)       begin miscompares++; $display("[TB] FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, el); end
         vectors++; if (div_zero !== ez) begin miscompares++; $display("[TB] FAIL rnd%0d_div_zero op=%0d: got %b expected %b", i, o, div_zero, ez); end
         vectors++; if (overflow !== ev) begin miscompares++; $display("[TB] FAIL rnd%0d_overflow op=%0d: got %b expected %b", i, o, overflow, ev); end
         last_hi = eh;
         last_lo = el;
         last_z  = ez;
         last_v  = ev;
      end
   endtask

   task automatic test_flush();
      int edges;
      bit saw_done;
      @(negedge clk);
      start = 1'b1;
      op    = 2'd0;
      op_a  = 32'd6;
      op_b  = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      while (edges < 10) begin
         @(posedge clk);
         #1;
         edges++;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_done: got %b expected 0", saw_done); end
      vectors++; if (hi !== last_hi)    begin miscompares++; $display("[TB] FAIL flush_hi_hold: got %h expected %h", hi, last_hi); end
      vectors++; if (lo !== last_lo)    begin miscompares++; $display("[TB] FAIL flush_lo_hold: got %h expected %h", lo, last_lo); end
      vectors++; if (div_zero !== last_z) begin miscompares++; $display("[TB] FAIL flush_div_zero_hold: got %b expected %b", div_zero, last_z); end
      vectors++; if (overflow !== last_v) begin miscompares++; $display("[TB] FAIL flush_overflow_hold: got %b expected %b", overflow, last_v); end
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'd3;
      op_a  = 32'd9;
      op_b  = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_beats_start: got busy %b expected 0", busy); end
      issue(2'd0, 32'd6, 32'd7, edges);
      vectors++; if (edges !== 34) begin miscompares++; $display("[TB] FAIL restart_latency: got %0d expected 34", edges); end
      vectors++; if (lo !== 32'd42) begin miscompares++; $display("[TB] FAIL restart_lo: got %h expected 0000002a", lo); end
      vectors++; if (hi !== 32'd0)  begin miscompares++; $display("[TB] FAIL restart_hi: got %h expected 00000000", hi); end
      last_hi = 32'd0;
      last_lo = 32'd42;
      last_z  = 1'b0;
      last_v  = 1'b0;
   endtask

   task automatic test_busy_ignore();
      int edges;
      @(negedge clk);
      start = 1'b1;
      op    = 2'd1;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      @(posedge clk);
      #1;
      edges = 1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_after_accept: got %b expected 1", busy); end
      op   = 2'd3;
      op_a = 32'd9;
      op_b = 32'd3;
      repeat (4) begin
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      wait_done(edges);
      vectors++; if (edges !== 34)    begin miscompares++; $display("[TB] FAIL busy_ignore_latency: got %0d expected 34", edges); end
      vectors++; if (lo !== 32'd3000) begin miscompares++; $display("[TB] FAIL busy_ignore_lo: got %h expected 00000bb8", lo); end
      vectors++; if (hi !== 32'd0)    begin miscompares++; $display("[TB] FAIL busy_ignore_hi: got %h expected 00000000", hi); end
      @(posedge clk);
      #1;
      vectors++; if (busy !== 1'b0)   begin miscompares++; $display("[TB] FAIL busy_ignore_no_queue: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int edges;
      issue(2'd3, 32'd100, 32'd7, edges);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
      start = 1'b1;
      op    = 2'd0;
      op_a  = 32'hFFFFFFFD;
      op_b  = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_pulse: got %b expected 0", done); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accepted: got busy %b expected 1", busy); end
      wait_done(edges);
      vectors++; if (edges !== 34)        begin miscompares++; $display("[TB] FAIL b2b_spacing: got %0d expected 34", edges); end
      vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL b2b_hi: got %h expected ffffffff", hi); end
      vectors++; if (lo !== 32'hFFFFFFEB) begin miscompares++; $display("[TB] FAIL b2b_lo: got %h expected ffffffeb", lo); end
      @(posedge clk);
      #1;
      vectors++; if (done !== 1'b0)       begin miscompares++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done); end
      vectors++; if (lo !== 32'hFFFFFFEB) begin miscompares++; $display("[TB] FAIL b2b_lo_hold: got %h expected ffffffeb", lo); end
   endtask

   task automatic test_async_reset();
      int edges;
      issue(2'd2, 32'd5, 32'd0, edges);
      vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_div_zero: got %b expected 1", div_zero); end
      @(negedge clk);
      start = 1'b1;
      op    = 2'd0;
      op_a  = 32'd6;
      op_b  = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0)     begin miscompares++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
      vectors++; if (hi !== '0)         begin miscompares++; $display("[TB] FAIL areset_hi: got %h expected 0", hi); end
      vectors++; if (lo !== '0)         begin miscompares++; $display("[TB] FAIL areset_lo: got %h expected 0", lo); end
      vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_div_zero: got %b expected 0", div_zero); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_overflow: got %b expected 0", overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'd1, 32'd12345, 32'd1000, edges);
      vectors++; if (lo !== 32'd12345000) begin miscompares++; $display("[TB] FAIL post_reset_lo: got %h expected %h", lo, 32'd12345000); end
      vectors++; if (edges !== 34)        begin miscompares++; $display("[TB] FAIL post_reset_latency: got %0d expected 34", edges); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_busy_ignore();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
